// File: rtl/sig_div.sv
// sig_div: sequential 8-by-4 signed divider, restoring division on magnitudes, one quotient bit per cycle
//   iClk   : clock, rising edge
//   iRst   : asynchronous active-high reset
//   iStart : request, sampled only while idle
//   iY     : 8-bit signed dividend
//   iX2    : 4-bit signed divisor
//   oQ     : 8-bit signed quotient, held until the next result
//   oR     : 4-bit signed remainder, sign follows the dividend
//   oErr   : last result was a divide-by-zero or -128/-1 overflow
//   oBusy  : operation in progress
//   oDone  : one-cycle result strobe
module sig_div (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iStart,
    input  logic [7:0] iY,
    input  logic [3:0] iX2,
    output logic [7:0] oQ,
    output logic [3:0] oR,
    output logic       oErr,
    output logic       oBusy,
    output logic       oDone
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    logic [1:0] state;
    logic [2:0] cnt;
    logic [7:0] dq;
    logic [3:0] d, pr;
    logic       sq, sr, e, ov;
    logic [7:0] ymag;
    logic [3:0] xmag;
    logic [4:0] sh, df;
    logic       z, o;
    // dq holds the unsigned dividend magnitude; 8 bits suffice since |-128| = 128.
    // Quotient bits shift into its LSB as dividend bits leave its MSB.
    always_comb begin
        ymag = iY[7] ? -iY : iY;
        xmag = iX2[3] ? -iX2 : iX2;
        z    = iX2 == 4'h0;
        o    = iY == 8'h80 && iX2 == 4'hF;
        sh   = {pr, dq[7]};
        df   = sh - {1'b0, d};
    end
    assign oBusy = state != IDLE;
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= 3'd0;
            dq    <= 8'h00;
            d     <= 4'h0;
            pr    <= 4'h0;
            sq    <= 1'b0;
            sr    <= 1'b0;
            e     <= 1'b0;
            ov    <= 1'b0;
            oQ    <= 8'h00;
            oR    <= 4'h0;
            oErr  <= 1'b0;
            oDone <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state)
                IDLE: if (iStart) begin
                    dq    <= ymag;
                    d     <= xmag;
                    pr    <= 4'h0;
                    cnt   <= 3'd0;
                    sq    <= iY[7] ^ iX2[3];
                    sr    <= iY[7];
                    e     <= z || o;
                    ov    <= o;
                    state <= (z || o) ? FIX : CALC;
                end
                CALC: begin
                    // df[4] set means the trial subtraction went negative: restore
                    pr    <= df[4] ? sh[3:0] : df[3:0];
                    dq    <= {dq[6:0], ~df[4]};
                    cnt   <= cnt + 3'd1;
                    state <= (cnt == 3'd7) ? FIX : CALC;
                end
                FIX: begin
                    oQ    <= e ? (ov ? 8'h80 : 8'h00) : (sq ? -dq : dq);
                    oR    <= e ? 4'h0 : (sr ? -pr : pr);
                    oErr  <= e;
                    oDone <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sig_div.sv
// tb_sig_div: self-checking bench for sig_div with an arithmetic reference model and directed vectors
module tb_sig_div;
    logic       iClk = 1'b0, iRst = 1'b1, iStart = 1'b0;
    logic [7:0] iY = 8'h00;
    logic [3:0] iX2 = 4'h0;
    logic [7:0] oQ;
    logic [3:0] oR;
    logic       oErr, oBusy, oDone;
    int total = 0, passed = 0;

    sig_div dut (.iClk(iClk), .iRst(iRst), .iStart(iStart), .iY(iY), .iX2(iX2),
                 .oQ(oQ), .oR(oR), .oErr(oErr), .oBusy(oBusy), .oDone(oDone));

    always #5 iClk = ~iClk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Reference model: remaining-cycle countdown plus plain signed arithmetic
    int         mcnt = 0, py = 0, px = 0, my = 0, mx = 0;
    logic [7:0] pq = 8'h00, mq = 8'h00;
    logic [3:0] pr = 4'h0, mr = 4'h0;
    logic       pe = 1'b0, me = 1'b0, mdone = 1'b0;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mcnt = 0; mdone = 1'b0; mq = 8'h00; mr = 4'h0; me = 1'b0;
        end else begin
            mdone = 1'b0;
            if (mcnt > 0) begin
                mcnt--;
                if (mcnt == 0) begin
                    mdone = 1'b1; mq = pq; mr = pr; me = pe; my = py; mx = px;
                end
            end else if (iStart) begin
                py = int'($signed(iY));
                px = int'($signed(iX2));
                if (px == 0) begin
                    pq = 8'h00; pr = 4'h0; pe = 1'b1;
                end else if (py == -128 && px == -1) begin
                    pq = 8'h80; pr = 4'h0; pe = 1'b1;
                end else begin
                    pq = 8'(py / px); pr = 4'(py % px); pe = 1'b0;
                end
                mcnt = pe ? 1 : 9;
            end
        end
    end

    // Every-cycle comparison against the model, plus product cross-check on results
    always @(negedge iClk) begin
        chk("busy", int'(oBusy), int'(mcnt > 0));
        chk("done", int'(oDone), int'(mdone));
        chk("quot", int'(oQ), int'(mq));
        chk("rem", int'(oR), int'(mr));
        chk("err", int'(oErr), int'(me));
        if (mdone && !me)
            chk("product", int'($signed(oQ)) * mx + int'($signed(oR)), my);
    end

    task automatic run_op(input logic [7:0] y, input logic [3:0] x, input int lat, input bit glitch);
        int n;
        @(negedge iClk);
        iY = y; iX2 = x; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        n = 0;
        while (n <= 20) begin
            @(negedge iClk);
            n++;
            if (glitch && n == 3) begin iStart = 1'b1; iY = 8'h01; iX2 = 4'h1; end
            if (glitch && n == 4) iStart = 1'b0;
            if (oDone) break;
        end
        chk("done_seen", int'(oDone), 1);
        chk("latency", n - 1, lat);
    endtask

    initial begin
        int d1, d2, d3, nd;
        repeat (2) @(negedge iClk);
        chk("rst_q", int'(oQ), 0);
        chk("rst_r", int'(oR), 0);
        chk("rst_flags", int'({oErr, oBusy, oDone}), 0);
        iRst = 1'b0;

        run_op(8'h64, 4'h7, 9, 0);
        chk("100/7 q", int'(oQ), 8'h0E); chk("100/7 r", int'(oR), 4'h2); chk("100/7 e", int'(oErr), 0);
        run_op(8'h9C, 4'h7, 9, 0);
        chk("-100/7 q", int'(oQ), 8'hF2); chk("-100/7 r", int'(oR), 4'hE);
        run_op(8'h64, 4'h9, 9, 0);
        chk("100/-7 q", int'(oQ), 8'hF2); chk("100/-7 r", int'(oR), 4'h2);
        run_op(8'h9C, 4'h9, 9, 0);
        chk("-100/-7 q", int'(oQ), 8'h0E); chk("-100/-7 r", int'(oR), 4'hE);
        run_op(8'h80, 4'h1, 9, 0);
        chk("-128/1 q", int'(oQ), 8'h80); chk("-128/1 r", int'(oR), 0); chk("-128/1 e", int'(oErr), 0);
        run_op(8'h25, 4'h0, 1, 0);
        chk("37/0 e", int'(oErr), 1); chk("37/0 q", int'(oQ), 0); chk("37/0 r", int'(oR), 0);
        run_op(8'h80, 4'hF, 1, 0);
        chk("ovf e", int'(oErr), 1); chk("ovf q", int'(oQ), 8'h80); chk("ovf r", int'(oR), 0);

        run_op(8'h64, 4'h7, 9, 1);
        chk("glitch q", int'(oQ), 8'h0E); chk("glitch r", int'(oR), 4'h2);

        // Start held high: results every 10 cycles
        @(negedge iClk);
        iY = 8'h64; iX2 = 4'h7; iStart = 1'b1;
        d1 = -1; d2 = -1; d3 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge iClk);
            if (oDone) begin
                if (d1 < 0) d1 = i; else if (d2 < 0) d2 = i; else if (d3 < 0) d3 = i;
            end
        end
        iStart = 1'b0;
        chk("b2b gap1", d2 - d1, 10);
        chk("b2b gap2", d3 - d2, 10);
        repeat (12) @(negedge iClk);

        // Reset during CALC cycle 4
        @(negedge iClk);
        iY = 8'h64; iX2 = 4'h7; iStart = 1'b1;
        @(posedge iClk);
        #1 iStart = 1'b0;
        repeat (4) @(negedge iClk);
        #2 iRst = 1'b1;
        #1;
        chk("arst q", int'(oQ), 0); chk("arst r", int'(oR), 0);
        chk("arst flags", int'({oErr, oBusy, oDone}), 0);
        @(negedge iClk);
        #2 iRst = 1'b0;
        nd = 0;
        repeat (12) begin @(negedge iClk); if (oDone) nd++; end
        chk("no done after reset", nd, 0);
        run_op(8'hF9, 4'h3, 9, 0);
        chk("-7/3 q", int'(oQ), 8'hFE); chk("-7/3 r", int'(oR), 4'hF);

        for (int y = 0; y < 256; y++)
            for (int x = 0; x < 16; x++)
                run_op(8'(y), 4'(x), (x == 0 || (y == 128 && x == 15)) ? 1 : 9, 0);

        @(negedge iClk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
